// File: rtl/clock_core_param_if.sv
// clock_core_param_if: control keys and BCD display bundle between the clock core and its user.
interface clock_core_param_if;
    logic       EN;
    logic       Ctrl24To12;
    logic       AdjH;
    logic       AdjM;
    logic       AlarmSet;
    logic       AlarmEn;
    logic       Snooze;
    logic [7:0] Hour;
    logic [7:0] Min;
    logic [7:0] Sec;
    logic       PM;
    logic       Tick1Hz;
    logic       LEDAlarm;
    logic       Chime;

    modport master (
        output EN, Ctrl24To12, AdjH, AdjM, AlarmSet, AlarmEn, Snooze,
        input  Hour, Min, Sec, PM, Tick1Hz, LEDAlarm, Chime
    );

    modport slave (
        input  EN, Ctrl24To12, AdjH, AdjM, AlarmSet, AlarmEn, Snooze,
        output Hour, Min, Sec, PM, Tick1Hz, LEDAlarm, Chime
    );
endinterface

// File: rtl/clock_core_param.sv
// clock_core_param: 1 Hz BCD HH:MM:SS timekeeper with 12/24 h display, auto-repeat adjust, alarm, snooze and chime.
module clock_core_param #(
    parameter int DIV        = 50_000_000,
    parameter int REPEAT_DIV = 25_000_000,
    parameter int ALARM_SECS = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int CHIME_SECS = 2
) (
    input logic               CP50,
    input logic               nCR,
    clock_core_param_if.slave io
);
    localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
    localparam int RW = REPEAT_DIV > 1 ? $clog2(REPEAT_DIV) : 1;
    localparam int AW = $clog2(ALARM_SECS + 1);
    localparam int SW = $clog2(60 * SNOOZE_MIN + 1);
    localparam int CW = $clog2(CHIME_SECS + 1);
    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
    localparam logic [RW-1:0] R_LAST = RW'(REPEAT_DIV - 1);
    localparam logic [AW-1:0] A_LAST = AW'(ALARM_SECS - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CHIME_SECS - 1);
    localparam logic [SW-1:0] S_LOAD = SW'(60 * SNOOZE_MIN);

    function automatic logic [7:0] inc60(input logic [7:0] v);
        return v[3:0] == 4'd9 ? (v[7:4] == 4'd5 ? 8'h00 : {v[7:4] + 4'd1, 4'd0}) : {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc24(input logic [7:0] v);
        return v == 8'h23 ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    logic [PW-1:0] pre_q, pre_d;
    logic [2:0]    kh_q, kh_d, km_q, km_d, ks_q, ks_d;
    logic [RW-1:0] rep_h_q, rep_h_d, rep_m_q, rep_m_d;
    logic [7:0]    hr_q, hr_d, mn_q, mn_d, sc_q, sc_d, ah_q, ah_d, am_q, am_d;
    logic          ring_q, ring_d, chime_q, chime_d;
    logic [AW-1:0] ring_cnt_q, ring_cnt_d;
    logic [SW-1:0] snz_q, snz_d;
    logic [CW-1:0] chime_cnt_q, chime_cnt_d;

    logic       tick, h_rise, m_rise, s_rise, h_step, m_step, sc_wrap, mn_wrap;
    logic       alarm_hit, snz_edge, snz_fire, ring_end, chime_hit, chime_end;
    logic [7:0] disp_h, h12_bcd;
    logic [4:0] hb, h12;

    always_comb begin
        tick      = io.EN && pre_q == P_LAST;
        pre_d     = io.EN ? (tick ? '0 : pre_q + 1'b1) : pre_q;
        // bit0/bit1 form the synchroniser, bit2 holds the previous synchronised level for edge detect
        kh_d      = {kh_q[1:0], io.AdjH};
        km_d      = {km_q[1:0], io.AdjM};
        ks_d      = {ks_q[1:0], io.Snooze};
        h_rise    = kh_q[1] && !kh_q[2];
        m_rise    = km_q[1] && !km_q[2];
        s_rise    = ks_q[1] && !ks_q[2];
        h_step    = h_rise || (kh_q[1] && rep_h_q == R_LAST);
        m_step    = m_rise || (km_q[1] && rep_m_q == R_LAST);
        rep_h_d   = (!kh_q[1] || h_step) ? '0 : rep_h_q + 1'b1;
        rep_m_d   = (!km_q[1] || m_step) ? '0 : rep_m_q + 1'b1;
        sc_wrap   = sc_q == 8'h59;
        mn_wrap   = mn_q == 8'h59;
        // a stepped field advances once; the tick carry into it is swallowed
        sc_d      = tick ? inc60(sc_q) : sc_q;
        mn_d      = ((m_step && !io.AlarmSet) || (tick && sc_wrap)) ? inc60(mn_q) : mn_q;
        hr_d      = ((h_step && !io.AlarmSet) || (tick && sc_wrap && mn_wrap)) ? inc24(hr_q) : hr_q;
        ah_d      = (h_step && io.AlarmSet) ? inc24(ah_q) : ah_q;
        am_d      = (m_step && io.AlarmSet) ? inc60(am_q) : am_q;
        alarm_hit = tick && io.AlarmEn && !ring_q && hr_d == ah_q && mn_d == am_q && sc_d == 8'h00;
        snz_edge  = s_rise && ring_q;
        snz_fire  = tick && snz_q == SW'(1);
        ring_end  = tick && ring_q && ring_cnt_q == A_LAST;
        ring_d    = !io.AlarmEn ? 1'b0 : snz_edge ? 1'b0 : (alarm_hit || snz_fire) ? 1'b1 : ring_end ? 1'b0 : ring_q;
        ring_cnt_d = (!io.AlarmEn || snz_edge || alarm_hit || snz_fire || ring_end) ? '0 :
                     (tick && ring_q) ? ring_cnt_q + 1'b1 : ring_cnt_q;
        snz_d     = !io.AlarmEn ? '0 : snz_edge ? S_LOAD : (tick && snz_q != '0) ? snz_q - 1'b1 : snz_q;
        chime_hit = tick && mn_d == 8'h00 && sc_d == 8'h00;
        chime_end = tick && chime_q && chime_cnt_q == C_LAST;
        chime_d   = chime_hit ? 1'b1 : chime_end ? 1'b0 : chime_q;
        chime_cnt_d = (chime_hit || chime_end) ? '0 : (tick && chime_q) ? chime_cnt_q + 1'b1 : chime_cnt_q;
        disp_h    = io.AlarmSet ? ah_q : hr_q;
        hb        = 5'(disp_h[7:4]) * 5'd10 + 5'(disp_h[3:0]);
        h12       = hb == 5'd0 ? 5'd12 : hb > 5'd12 ? hb - 5'd12 : hb;
        h12_bcd   = h12 >= 5'd10 ? {4'd1, 4'(h12 - 5'd10)} : {4'd0, h12[3:0]};
    end

    always_ff @(posedge CP50 or negedge nCR) begin
        if (!nCR) begin
            pre_q       <= '0;
            kh_q        <= '0;
            km_q        <= '0;
            ks_q        <= '0;
            rep_h_q     <= '0;
            rep_m_q     <= '0;
            hr_q        <= 8'h00;
            mn_q        <= 8'h00;
            sc_q        <= 8'h00;
            ah_q        <= 8'h00;
            am_q        <= 8'h00;
            ring_q      <= 1'b0;
            ring_cnt_q  <= '0;
            snz_q       <= '0;
            chime_q     <= 1'b0;
            chime_cnt_q <= '0;
        end else begin
            pre_q       <= pre_d;
            kh_q        <= kh_d;
            km_q        <= km_d;
            ks_q        <= ks_d;
            rep_h_q     <= rep_h_d;
            rep_m_q     <= rep_m_d;
            hr_q        <= hr_d;
            mn_q        <= mn_d;
            sc_q        <= sc_d;
            ah_q        <= ah_d;
            am_q        <= am_d;
            ring_q      <= ring_d;
            ring_cnt_q  <= ring_cnt_d;
            snz_q       <= snz_d;
            chime_q     <= chime_d;
            chime_cnt_q <= chime_cnt_d;
        end
    end

    assign io.Hour     = io.Ctrl24To12 ? disp_h : h12_bcd;
    assign io.Min      = io.AlarmSet ? am_q : mn_q;
    assign io.Sec      = io.AlarmSet ? 8'h00 : sc_q;
    assign io.PM       = disp_h >= 8'h12;
    assign io.Tick1Hz  = tick;
    assign io.LEDAlarm = ring_q;
    assign io.Chime    = chime_q;
endmodule

// File: tb/tb_clock_core_param.sv
// tb_clock_core_param: directed scenarios for clock_core_param with a 4-cycle second.
module tb_clock_core_param;
    logic CP50 = 1'b0;
    logic nCR  = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    clock_core_param_if bus();

    clock_core_param #(
        .DIV(4), .REPEAT_DIV(8), .ALARM_SECS(3), .SNOOZE_MIN(1), .CHIME_SECS(2)
    ) dut (
        .CP50(CP50),
        .nCR (nCR),
        .io  (bus)
    );

    always #5 CP50 = ~CP50;

    task automatic cyc(input int n);
        repeat (n) @(posedge CP50);
        #1;
    endtask

    task automatic press(input bit hour, input int n);
        for (int k = 0; k < n; k++) begin
            if (hour) bus.AdjH = 1'b1; else bus.AdjM = 1'b1;
            cyc(3);
            bus.AdjH = 1'b0;
            bus.AdjM = 1'b0;
            cyc(3);
        end
    endtask

    task automatic do_reset();
        nCR = 1'b0;
        bus.EN = 1'b0;
        cyc(2);
        nCR = 1'b1;
    endtask

    task automatic test_reset();
        bus.EN = 1'b0; bus.Ctrl24To12 = 1'b1; bus.AdjH = 1'b0; bus.AdjM = 1'b0;
        bus.AlarmSet = 1'b0; bus.AlarmEn = 1'b0; bus.Snooze = 1'b0;
        cyc(3);
        n_chk++; if (bus.Hour !== 8'h00) begin n_fail++; $display("FAIL rst_hour24: got %h want 00", bus.Hour); end
        n_chk++; if (bus.Min !== 8'h00) begin n_fail++; $display("FAIL rst_min: got %h want 00", bus.Min); end
        n_chk++; if (bus.Sec !== 8'h00) begin n_fail++; $display("FAIL rst_sec: got %h want 00", bus.Sec); end
        n_chk++; if ({bus.PM, bus.Tick1Hz, bus.LEDAlarm, bus.Chime} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", {bus.PM, bus.Tick1Hz, bus.LEDAlarm, bus.Chime}); end
        bus.Ctrl24To12 = 1'b0;
        #1;
        n_chk++; if (bus.Hour !== 8'h12) begin n_fail++; $display("FAIL rst_hour12: got %h want 12", bus.Hour); end
        bus.Ctrl24To12 = 1'b1;
    endtask

    task automatic test_count();
        cyc(1);
        nCR = 1'b1;
        bus.EN = 1'b1;
        for (int i = 0; i < 240; i++) begin
            n_chk++; if (bus.Tick1Hz !== (i % 4 == 3)) begin n_fail++; $display("FAIL t1_tick[%0d]: got %b want %b", i, bus.Tick1Hz, i % 4 == 3); end
            if (i == 236) begin
                n_chk++; if ({bus.Min, bus.Sec} !== 16'h0059) begin n_fail++; $display("FAIL t1_sec59: got %h want 0059", {bus.Min, bus.Sec}); end
            end
            cyc(1);
        end
        n_chk++; if ({bus.Min, bus.Sec} !== 16'h0100) begin n_fail++; $display("FAIL t1_min01: got %h want 0100", {bus.Min, bus.Sec}); end
        n_chk++; if (bus.Chime !== 1'b0) begin n_fail++; $display("FAIL t1_nochime: got %b want 0", bus.Chime); end
        bus.EN = 1'b0;
    endtask

    task automatic test_rollover();
        do_reset();
        bus.EN = 1'b1;
        cyc(232);
        bus.EN = 1'b0;
        press(1'b1, 23);
        press(1'b0, 59);
        n_chk++; if ({bus.Hour, bus.Min, bus.Sec} !== 24'h235958) begin n_fail++; $display("FAIL t2_preload: got %h want 235958", {bus.Hour, bus.Min, bus.Sec}); end
        bus.EN = 1'b1;
        cyc(4);
        n_chk++; if (bus.Sec !== 8'h59) begin n_fail++; $display("FAIL t2_sec59: got %h want 59", bus.Sec); end
        cyc(4);
        n_chk++; if ({bus.Hour, bus.Min, bus.Sec} !== 24'h000000) begin n_fail++; $display("FAIL t2_midnight: got %h want 000000", {bus.Hour, bus.Min, bus.Sec}); end
        n_chk++; if (bus.Chime !== 1'b1) begin n_fail++; $display("FAIL t2_chime_on: got %b want 1", bus.Chime); end
        bus.Ctrl24To12 = 1'b0;
        #1;
        n_chk++; if ({bus.Hour, bus.PM} !== 9'h024) begin n_fail++; $display("FAIL t2_12h: got %h/%b want 12/0", bus.Hour, bus.PM); end
        bus.Ctrl24To12 = 1'b1;
        cyc(7);
        n_chk++; if (bus.Chime !== 1'b1) begin n_fail++; $display("FAIL t2_chime_hold: got %b want 1", bus.Chime); end
        cyc(1);
        n_chk++; if (bus.Chime !== 1'b0) begin n_fail++; $display("FAIL t2_chime_off: got %b want 0", bus.Chime); end
        bus.EN = 1'b0;
    endtask

    task automatic test_12h();
        press(1'b1, 13);
        press(1'b0, 5);
        bus.Ctrl24To12 = 1'b0;
        #1;
        n_chk++; if ({bus.Hour, bus.PM} !== {8'h01, 1'b1}) begin n_fail++; $display("FAIL t3_12h: got %h/%b want 01/1", bus.Hour, bus.PM); end
        bus.Ctrl24To12 = 1'b1;
        #1;
        n_chk++; if ({bus.Hour, bus.Min, bus.PM} !== {16'h1305, 1'b1}) begin n_fail++; $display("FAIL t3_24h: got %h%h/%b want 1305/1", bus.Hour, bus.Min, bus.PM); end
        bus.AlarmSet = 1'b1;
        #1;
        n_chk++; if ({bus.Hour, bus.Min, bus.Sec, bus.PM} !== {24'h000000, 1'b0}) begin n_fail++; $display("FAIL t3_alarm_view: got %h%h%h/%b want 000000/0", bus.Hour, bus.Min, bus.Sec, bus.PM); end
        bus.AlarmSet = 1'b0;
    endtask

    task automatic test_adjust_repeat();
        press(1'b0, 53);
        n_chk++; if (bus.Min !== 8'h58) begin n_fail++; $display("FAIL t4_min58: got %h want 58", bus.Min); end
        bus.AdjM = 1'b1;
        cyc(2);
        n_chk++; if (bus.Min !== 8'h58) begin n_fail++; $display("FAIL t4_latency: got %h want 58", bus.Min); end
        cyc(1);
        n_chk++; if (bus.Min !== 8'h59) begin n_fail++; $display("FAIL t4_first: got %h want 59", bus.Min); end
        cyc(7);
        n_chk++; if (bus.Min !== 8'h59) begin n_fail++; $display("FAIL t4_gap: got %h want 59", bus.Min); end
        cyc(1);
        n_chk++; if (bus.Min !== 8'h00) begin n_fail++; $display("FAIL t4_wrap: got %h want 00", bus.Min); end
        cyc(8);
        n_chk++; if (bus.Min !== 8'h01) begin n_fail++; $display("FAIL t4_rep01: got %h want 01", bus.Min); end
        cyc(8);
        n_chk++; if (bus.Min !== 8'h02) begin n_fail++; $display("FAIL t4_rep02: got %h want 02", bus.Min); end
        cyc(8);
        n_chk++; if (bus.Min !== 8'h03) begin n_fail++; $display("FAIL t4_rep03: got %h want 03", bus.Min); end
        cyc(5);
        bus.AdjM = 1'b0;
        cyc(10);
        n_chk++; if ({bus.Hour, bus.Min, bus.Sec} !== 24'h130302) begin n_fail++; $display("FAIL t4_final: got %h want 130302", {bus.Hour, bus.Min, bus.Sec}); end
    endtask

    task automatic test_alarm();
        do_reset();
        bus.AlarmSet = 1'b1;
        press(1'b0, 2);
        n_chk++; if ({bus.Hour, bus.Min, bus.Sec} !== 24'h000200) begin n_fail++; $display("FAIL t5_alarm_set: got %h want 000200", {bus.Hour, bus.Min, bus.Sec}); end
        bus.AlarmSet = 1'b0;
        bus.EN = 1'b1;
        cyc(236);
        bus.EN = 1'b0;
        press(1'b0, 1);
        n_chk++; if ({bus.Hour, bus.Min, bus.Sec} !== 24'h000159) begin n_fail++; $display("FAIL t5_preload: got %h want 000159", {bus.Hour, bus.Min, bus.Sec}); end
        bus.AlarmEn = 1'b1;
        bus.EN = 1'b1;
        cyc(4);
        n_chk++; if ({bus.Min, bus.Sec, bus.LEDAlarm} !== {16'h0200, 1'b1}) begin n_fail++; $display("FAIL t5_ring: got %h%h/%b want 0200/1", bus.Min, bus.Sec, bus.LEDAlarm); end
        cyc(11);
        n_chk++; if (bus.LEDAlarm !== 1'b1) begin n_fail++; $display("FAIL t5_ring_hold: got %b want 1", bus.LEDAlarm); end
        cyc(1);
        n_chk++; if (bus.LEDAlarm !== 1'b0) begin n_fail++; $display("FAIL t5_ring_end: got %b want 0", bus.LEDAlarm); end
        bus.EN = 1'b0;
        bus.AlarmSet = 1'b1;
        press(1'b0, 1);
        bus.AlarmSet = 1'b0;
        bus.EN = 1'b1;
        cyc(227);
        n_chk++; if (bus.LEDAlarm !== 1'b0) begin n_fail++; $display("FAIL t5_pre_ring2: got %b want 0", bus.LEDAlarm); end
        cyc(1);
        n_chk++; if (bus.LEDAlarm !== 1'b1) begin n_fail++; $display("FAIL t5_ring2: got %b want 1", bus.LEDAlarm); end
        cyc(4);
        bus.Snooze = 1'b1;
        cyc(3);
        bus.Snooze = 1'b0;
        n_chk++; if (bus.LEDAlarm !== 1'b0) begin n_fail++; $display("FAIL t5_snooze: got %b want 0", bus.LEDAlarm); end
        cyc(236);
        n_chk++; if (bus.LEDAlarm !== 1'b0) begin n_fail++; $display("FAIL t5_snooze_wait: got %b want 0", bus.LEDAlarm); end
        cyc(1);
        n_chk++; if (bus.LEDAlarm !== 1'b1) begin n_fail++; $display("FAIL t5_rering: got %b want 1", bus.LEDAlarm); end
    endtask

    task automatic test_reset_ringing();
        nCR = 1'b0;
        bus.EN = 1'b0;
        #1;
        n_chk++; if ({bus.Hour, bus.Min, bus.Sec} !== 24'h000000) begin n_fail++; $display("FAIL t6_rst_time: got %h want 000000", {bus.Hour, bus.Min, bus.Sec}); end
        n_chk++; if ({bus.PM, bus.Tick1Hz, bus.LEDAlarm, bus.Chime} !== 4'b0000) begin n_fail++; $display("FAIL t6_rst_flags: got %b want 0000", {bus.PM, bus.Tick1Hz, bus.LEDAlarm, bus.Chime}); end
        cyc(1);
        nCR = 1'b1;
        bus.AlarmSet = 1'b1;
        press(1'b0, 1);
        bus.AlarmSet = 1'b0;
        bus.EN = 1'b1;
        cyc(240);
        n_chk++; if (bus.LEDAlarm !== 1'b1) begin n_fail++; $display("FAIL t6_ring: got %b want 1", bus.LEDAlarm); end
        bus.AlarmEn = 1'b0;
        cyc(1);
        n_chk++; if (bus.LEDAlarm !== 1'b0) begin n_fail++; $display("FAIL t6_alarm_off: got %b want 0", bus.LEDAlarm); end
        bus.EN = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count();
        test_rollover();
        test_12h();
        test_adjust_repeat();
        test_alarm();
        test_reset_ringing();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
